bft_stream_tx: RTL and testbench

- Transmitter-side endpoint for the BFT network, the counterpart to a leaf's receive path.
- Accepts 32-bit words from a user/HLS producer over a vld/ack handshake and formats each word into a 49-bit BFT packet addressed to a configurable destination leaf/port.
- Drives the packet onto the BFT output bus, re-drives it when the BFT asserts resend, and enforces credit-based flow control from freespace-update packets returned by the destination.
- Used to inject streams (e.g. from host/DMA logic) into a page's input port.

---
 rtl/bft_stream_tx_if.sv | 43 ++++
 rtl/bft_stream_tx.sv | 105 ++++++++++
 tb/tb_bft_stream_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bft_stream_tx_if.sv
// bft_stream_tx_if: user-side and BFT-side signals of the stream transmitter.
// The master side is the producer/network; the slave side is the transmitter.
interface bft_stream_tx_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4,
  parameter int CREDIT_BITS   = 8
);
  logic [PACKET_BITS-1:0]   din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]   dout_leaf_interface2bft;
  logic                     resend;
  logic [NUM_LEAF_BITS-1:0] dest_leaf;
  logic [NUM_PORT_BITS-1:0] dest_port;
  logic [PAYLOAD_BITS-1:0]  din_user2tx;
  logic                     vld_user2tx;
  logic                     ack_tx2user;
  logic [CREDIT_BITS-1:0]   credit;

  modport master (
    output din_leaf_bft2interface,
    output resend,
    output dest_leaf,
    output dest_port,
    output din_user2tx,
    output vld_user2tx,
    input  dout_leaf_interface2bft,
    input  ack_tx2user,
    input  credit
  );

  modport slave (
    input  din_leaf_bft2interface,
    input  resend,
    input  dest_leaf,
    input  dest_port,
    input  din_user2tx,
    input  vld_user2tx,
    output dout_leaf_interface2bft,
    output ack_tx2user,
    output credit
  );
endinterface

// File: rtl/bft_stream_tx.sv
// bft_stream_tx: packs user words into BFT packets with resend
// handling and credit-based flow control from freespace updates.
module bft_stream_tx #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int SELF_LEAF             = 1,
  parameter int SELF_PORT             = 1,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic           clk,
  input logic           reset,
  bft_stream_tx_if.slave bus
);
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW-1:0] MAX_CREDIT =
    CW'(1 << NUM_BRAM_ADDR_BITS);
  localparam int LEAF_HI = PACKET_BITS - 2;
  localparam int PORT_HI = LEAF_HI - NUM_LEAF_BITS;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESEND
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [PACKET_BITS-1:0]   dout;
  logic [PACKET_BITS-1:0]   dout_n;
  logic [PACKET_BITS-1:0]   pkt;
  logic [PAYLOAD_BITS-1:0]  payload;
  logic [CW-1:0]            credit;
  logic [CW-1:0]            credit_n;
  logic [CW:0]              sum;
  logic [NUM_LEAF_BITS-1:0] in_leaf;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic                     ack;
  logic                     accept;
  logic                     update;

  assign payload = bus.din_user2tx;
  assign pkt = {1'b1, bus.dest_leaf, bus.dest_port,
                NUM_LEAF_BITS'(SELF_LEAF),
                NUM_PORT_BITS'(SELF_PORT), payload};

  assign ack    = reset && (credit != '0) && !bus.resend;
  assign accept = ack && bus.vld_user2tx;

  assign in_leaf = bus.din_leaf_bft2interface[LEAF_HI -: NUM_LEAF_BITS];
  assign in_port = bus.din_leaf_bft2interface[PORT_HI -: NUM_PORT_BITS];
  assign update  = bus.din_leaf_bft2interface[PACKET_BITS-1] &&
                   (in_leaf == NUM_LEAF_BITS'(SELF_LEAF)) &&
                   (in_port == '0);

  // accept implies credit >= 1, so the sum never underflows
  assign sum = {1'b0, credit}
             + (update ? (CW+1)'(FREESPACE_UPDATE_SIZE) : '0)
             - (CW+1)'(accept);
  assign credit_n = (sum > {1'b0, MAX_CREDIT}) ? MAX_CREDIT
                                               : sum[CW-1:0];

  always_comb begin
    state_n = state;
    dout_n  = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SEND;
          dout_n  = pkt;
        end
      end
      SEND, RESEND: begin
        if (bus.resend) begin
          state_n = RESEND;
          dout_n  = dout;
        end else if (accept) begin
          state_n = SEND;
          dout_n  = pkt;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      dout   <= '0;
      credit <= MAX_CREDIT;
    end else begin
      state  <= state_n;
      dout   <= dout_n;
      credit <= credit_n;
    end
  end

  assign bus.dout_leaf_interface2bft = dout;
  assign bus.ack_tx2user             = ack;
  assign bus.credit                  = credit;
endmodule

// File: tb/tb_bft_stream_tx.sv
// tb_bft_stream_tx: directed checks of packing, resend, credit
// accounting, saturation and reset for bft_stream_tx.
module tb_bft_stream_tx;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  bft_stream_tx_if bus ();

  bft_stream_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [48:0] upd_self;
  logic [48:0] upd_leaf5;
  logic [48:0] upd_port2;
  logic [48:0] upd_novld;

  initial begin
    errors = 0;
    checks = 0;
    upd_self  = {1'b1, 4'd1, 4'd0, 40'h0};
    upd_leaf5 = {1'b1, 4'd5, 4'd0, 40'h0};
    upd_port2 = {1'b1, 4'd1, 4'd2, 40'h0};
    upd_novld = {1'b0, 4'd1, 4'd0, 40'h0};

    reset = 1'b0;
    bus.din_leaf_bft2interface = '0;
    bus.resend      = 1'b0;
    bus.dest_leaf   = 4'd2;
    bus.dest_port   = 4'd3;
    bus.din_user2tx = '0;
    bus.vld_user2tx = 1'b0;
    step();
    step();
    chk("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);
    chk("rst_credit", 64'(bus.credit), 64'd128);
    chk("rst_ack", 64'(bus.ack_tx2user), 64'd0);

    reset = 1'b1;
    step();
    chk("idle_ack", 64'(bus.ack_tx2user), 64'd1);

    // single word
    bus.din_user2tx = 32'hDEADBEEF;
    bus.vld_user2tx = 1'b1;
    #1;
    chk("t1_ack", 64'(bus.ack_tx2user), 64'd1);
    step();
    bus.vld_user2tx = 1'b0;
    chk("t1_dout", 64'(bus.dout_leaf_interface2bft),
        64'h1_2311_DEADBEEF);
    chk("t1_credit", 64'(bus.credit), 64'd127);
    step();
    chk("t1_clear", 64'(bus.dout_leaf_interface2bft), 64'h0);

    // back-to-back words
    for (int i = 0; i < 4; i++) begin
      bus.din_user2tx = 32'(i);
      bus.vld_user2tx = 1'b1;
      step();
      chk("t2_dout", 64'(bus.dout_leaf_interface2bft),
          {15'h0, 17'h1_2311, 32'(i)});
    end
    bus.vld_user2tx = 1'b0;
    chk("t2_credit", 64'(bus.credit), 64'd123);
    step();
    chk("t2_clear", 64'(bus.dout_leaf_interface2bft), 64'h0);

    // resend holds the packet
    bus.din_user2tx = 32'hA5A5A5A5;
    bus.vld_user2tx = 1'b1;
    step();
    bus.resend = 1'b1;
    bus.din_user2tx = 32'h55555555;
    #1;
    chk("t3_ack", 64'(bus.ack_tx2user), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold", 64'(bus.dout_leaf_interface2bft),
          64'h1_2311_A5A5A5A5);
      chk("t3_ackhold", 64'(bus.ack_tx2user), 64'd0);
    end
    chk("t3_credit", 64'(bus.credit), 64'd122);
    bus.resend = 1'b0;
    bus.din_user2tx = 32'h11111111;
    #1;
    chk("t3_ackrel", 64'(bus.ack_tx2user), 64'd1);
    step();
    bus.vld_user2tx = 1'b0;
    chk("t3_next", 64'(bus.dout_leaf_interface2bft),
        64'h1_2311_11111111);
    chk("t3_credit2", 64'(bus.credit), 64'd121);
    step();

    // drain all credit
    for (int i = 0; i < 121; i++) begin
      bus.din_user2tx = 32'(i);
      bus.vld_user2tx = 1'b1;
      step();
    end
    chk("t4_credit0", 64'(bus.credit), 64'd0);
    chk("t4_ack0", 64'(bus.ack_tx2user), 64'd0);
    chk("t4_last", 64'(bus.dout_leaf_interface2bft),
        64'h1_2311_00000078);
    step();
    chk("t4_noacc", 64'(bus.dout_leaf_interface2bft), 64'h0);
    chk("t4_still0", 64'(bus.credit), 64'd0);
    bus.din_leaf_bft2interface = upd_self;
    step();
    bus.din_leaf_bft2interface = '0;
    chk("t4_ret", 64'(bus.credit), 64'd64);
    chk("t4_ack1", 64'(bus.ack_tx2user), 64'd1);
    bus.vld_user2tx = 1'b0;

    // saturation and ignored packets
    bus.din_leaf_bft2interface = upd_self;
    step();
    chk("t5_128", 64'(bus.credit), 64'd128);
    bus.din_leaf_bft2interface = '0;
    bus.din_user2tx = 32'h0BADF00D;
    bus.vld_user2tx = 1'b1;
    step();
    chk("t5_127", 64'(bus.credit), 64'd127);
    bus.din_leaf_bft2interface = upd_self;
    bus.din_user2tx = 32'h600DF00D;
    step();
    chk("t5_sat", 64'(bus.credit), 64'd128);
    chk("t5_dout", 64'(bus.dout_leaf_interface2bft),
        64'h1_2311_600DF00D);
    bus.din_leaf_bft2interface = upd_leaf5;
    step();
    chk("t5_leaf5", 64'(bus.credit), 64'd127);
    bus.vld_user2tx = 1'b0;
    bus.din_leaf_bft2interface = upd_port2;
    step();
    chk("t5_port2", 64'(bus.credit), 64'd127);
    bus.din_leaf_bft2interface = upd_novld;
    step();
    chk("t5_novld", 64'(bus.credit), 64'd127);
    bus.din_leaf_bft2interface = '0;

    // reset during resend
    bus.din_user2tx = 32'hCAFEF00D;
    bus.vld_user2tx = 1'b1;
    step();
    bus.vld_user2tx = 1'b0;
    chk("t6_credit", 64'(bus.credit), 64'd126);
    bus.resend = 1'b1;
    step();
    chk("t6_hold", 64'(bus.dout_leaf_interface2bft),
        64'h1_2311_CAFEF00D);
    reset = 1'b0;
    #1;
    chk("t6_ackrst", 64'(bus.ack_tx2user), 64'd0);
    step();
    chk("t6_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);
    chk("t6_credit128", 64'(bus.credit), 64'd128);
    chk("t6_ack", 64'(bus.ack_tx2user), 64'd0);
    reset = 1'b1;
    bus.resend = 1'b0;
    bus.dest_leaf = 4'd4;
    bus.dest_port = 4'd5;
    bus.din_user2tx = 32'h12345678;
    bus.vld_user2tx = 1'b1;
    step();
    bus.vld_user2tx = 1'b0;
    chk("t6_after", 64'(bus.dout_leaf_interface2bft),
        64'h1_4511_12345678);
    chk("t6_credit127", 64'(bus.credit), 64'd127);
    step();
    chk("t6_clear", 64'(bus.dout_leaf_interface2bft), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
